// File: rtl/time_entry.sv
// Push-button editor for the microwave min:sec preset, kept as four BCD digits.
// Define TIME_ENTRY_AUTOREPEAT_EN to add hold-to-repeat on the up/down buttons.
module time_entry #(
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int BLINK_CYCLES  = 25000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       up,
    input  logic       down,
    input  logic       next,
    input  logic       clear,
    input  logic       lock,
    output logic [6:0] min,
    output logic [6:0] sec,
    output logic [1:0] sel,
    output logic [3:0] blank,
    output logic       valid
);

    // One counter width serves both the blink timer and the repeat timer.
    localparam int HR_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_MAX = (HR_MAX > BLINK_CYCLES) ? HR_MAX : BLINK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_CYCLES - 1);

    logic [3:0] su, st, mu, mt;
    logic       up_prev, down_prev, next_prev, clear_prev;
    logic       up_ev, down_ev, next_ev, clear_ev;
    logic       rep_up, rep_down;
    logic       inc, dec;
    logic [3:0] cur_digit, digit_top, new_digit;
    logic [CNT_W-1:0] blink_cnt;
    logic       blink_phase;

    assign up_ev    = up    & ~up_prev;
    assign down_ev  = down  & ~down_prev;
    assign next_ev  = next  & ~next_prev;
    assign clear_ev = clear & ~clear_prev;

    always_ff @(posedge clock) begin
        if (reset) begin
            up_prev    <= 1'b0;
            down_prev  <= 1'b0;
            next_prev  <= 1'b0;
            clear_prev <= 1'b0;
        end else begin
            up_prev    <= up;
            down_prev  <= down;
            next_prev  <= next;
            clear_prev <= clear;
        end
    end

`ifdef TIME_ENTRY_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_HOLD,
        RPT_REPEAT
    } rpt_state_t;

    rpt_state_t       rpt_state;
    logic             rpt_is_up;
    logic [CNT_W-1:0] rpt_cnt;
    logic             held, other, single_ev, cnt_done;

    always_comb begin
        held      = rpt_is_up ? up : down;
        other     = rpt_is_up ? down : up;
        single_ev = up_ev ^ down_ev;
        cnt_done  = (rpt_state == RPT_HOLD) ? (rpt_cnt == HOLD_LAST)
                                            : (rpt_cnt == REPEAT_LAST);
        rep_up    = 1'b0;
        rep_down  = 1'b0;
        if (rpt_state != RPT_IDLE && !lock && !clear_ev && !single_ev &&
            held && !other && cnt_done) begin
            rep_up   = rpt_is_up;
            rep_down = ~rpt_is_up;
        end
    end

    // The counter restarts on the triggering edge and on every repeat it issues.
    always_ff @(posedge clock) begin
        if (reset) begin
            rpt_state <= RPT_IDLE;
            rpt_is_up <= 1'b0;
            rpt_cnt   <= '0;
        end else if (lock || clear_ev) begin
            rpt_state <= RPT_IDLE;
        end else if (single_ev) begin
            rpt_state <= RPT_HOLD;
            rpt_is_up <= up_ev;
            rpt_cnt   <= '0;
        end else if (rpt_state != RPT_IDLE) begin
            if (!held || other) begin
                rpt_state <= RPT_IDLE;
            end else if (cnt_done) begin
                rpt_state <= RPT_REPEAT;
                rpt_cnt   <= '0;
            end else begin
                rpt_cnt <= rpt_cnt + CNT_ONE;
            end
        end
    end
`else
    assign rep_up   = 1'b0;
    assign rep_down = 1'b0;
`endif

    always_comb begin
        cur_digit = su;
        digit_top = 4'd9;
        unique case (sel)
            2'd0: begin cur_digit = su; digit_top = 4'd9; end
            2'd1: begin cur_digit = st; digit_top = 4'd5; end
            2'd2: begin cur_digit = mu; digit_top = 4'd9; end
            2'd3: begin cur_digit = mt; digit_top = 4'd9; end
        endcase
        inc       = up_ev | rep_up;
        dec       = down_ev | rep_down;
        new_digit = cur_digit;
        if (inc && !dec)
            new_digit = (cur_digit >= digit_top) ? 4'd0 : cur_digit + 4'd1;
        else if (dec && !inc)
            new_digit = (cur_digit == 4'd0 || cur_digit > digit_top) ? digit_top : cur_digit - 4'd1;
    end

    // The edit lands on the current digit before next moves the selection.
    always_ff @(posedge clock) begin
        if (reset) begin
            su  <= 4'd0;
            st  <= 4'd0;
            mu  <= 4'd0;
            mt  <= 4'd0;
            sel <= 2'd0;
        end else if (!lock) begin
            if (clear_ev) begin
                su  <= 4'd0;
                st  <= 4'd0;
                mu  <= 4'd0;
                mt  <= 4'd0;
                sel <= 2'd0;
            end else begin
                unique case (sel)
                    2'd0: su <= new_digit;
                    2'd1: st <= new_digit;
                    2'd2: mu <= new_digit;
                    2'd3: mt <= new_digit;
                endcase
                if (next_ev)
                    sel <= sel + 2'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || lock) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + CNT_ONE;
        end
    end

    assign sec   = 7'(st) * 7'd10 + 7'(su);
    assign min   = 7'(mt) * 7'd10 + 7'(mu);
    assign valid = |{su, st, mu, mt};
    assign blank = (lock || !blink_phase) ? 4'b0000 : (4'b0001 << sel);

endmodule
